// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: requester ports A and B plus the single memory port.
// slave is the arbiter's view; master is the view of the requesters and the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_wr;
    logic [ADDR_W-1:0] a_adr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;

    logic              b_req;
    logic              b_wr;
    logic [ADDR_W-1:0] b_adr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rvalid;

    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_d_in;
    logic              mem_mrd;
    logic              mem_mwr;
    logic [DATA_W-1:0] mem_d_out;

    modport slave (
        input  a_req, a_wr, a_adr, a_wdata,
        output a_ack, a_rdata, a_rvalid,
        input  b_req, b_wr, b_adr, b_wdata,
        output b_ack, b_rdata, b_rvalid,
        output mem_adr, mem_d_in, mem_mrd, mem_mwr,
        input  mem_d_out
    );

    modport master (
        output a_req, a_wr, a_adr, a_wdata,
        input  a_ack, a_rdata, a_rvalid,
        output b_req, b_wr, b_adr, b_wdata,
        input  b_ack, b_rdata, b_rvalid,
        input  mem_adr, mem_d_in, mem_mrd, mem_mwr,
        output mem_d_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter, one access per SERVE cycle, round-robin by default.
// Define ARB_FIXED_PRIO_EN to give requester A strict priority over B (last is then ignored).

// Per-requester read return: captures memory read data at the end of a served read cycle.
module mem_arbiter_rport #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= cap;
            if (cap) rdata <= d;
        end
    end
endmodule

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int NUM_PORTS = 2;
    localparam int PA = 0;
    localparam int PB = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;   // 0: A served last, 1: B served last

    logic [NUM_PORTS-1:0]             req, wr, sel, ack, cap, rvalid;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] adr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, rdata;
    logic [ADDR_W-1:0]                mem_adr_c;
    logic [DATA_W-1:0]                mem_din_c;

    assign req   = {bus.b_req,   bus.a_req};
    assign wr    = {bus.b_wr,    bus.a_wr};
    assign adr   = {bus.b_adr,   bus.a_adr};
    assign wdata = {bus.b_wdata, bus.a_wdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // A requester is never granted two cycles in a row; IDLE ties go by last (or to A when fixed).
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (req[PA] && req[PB]) begin
`ifdef ARB_FIXED_PRIO_EN
                    state_nxt = SERVE_A;
`else
                    state_nxt = last ? SERVE_A : SERVE_B;
`endif
                end else if (req[PA]) begin
                    state_nxt = SERVE_A;
                end else if (req[PB]) begin
                    state_nxt = SERVE_B;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SERVE_A: begin
                last_nxt = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
                state_nxt = (req[PB] && !req[PA]) ? SERVE_B : IDLE;
`else
                state_nxt = req[PB] ? SERVE_B : IDLE;
`endif
            end
            SERVE_B: begin
                last_nxt  = 1'b1;
                state_nxt = req[PA] ? SERVE_A : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel[PA] = (state == SERVE_A);
    assign sel[PB] = (state == SERVE_B);

    // Reset gates the strobes combinationally so an in-flight write never lands.
    assign ack = sel & {NUM_PORTS{!rst}};
    assign cap = ack & ~wr;

    always_comb begin
        mem_adr_c = '0;
        mem_din_c = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel[i]) begin
                mem_adr_c = adr[i];
                mem_din_c = wdata[i];
            end
        end
    end

    assign bus.mem_adr  = mem_adr_c;
    assign bus.mem_d_in = mem_din_c;
    assign bus.mem_mwr  = |(ack & wr);
    assign bus.mem_mrd  = |(ack & ~wr);
    assign bus.a_ack    = ack[PA];
    assign bus.b_ack    = ack[PB];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rport
        mem_arbiter_rport #(.DATA_W(DATA_W)) u_rport (
            .clk    (clk),
            .rst    (rst),
            .cap    (cap[gi]),
            .d      (bus.mem_d_out),
            .rdata  (rdata[gi]),
            .rvalid (rvalid[gi])
        );
    end

    assign bus.a_rdata  = rdata[PA];
    assign bus.b_rdata  = rdata[PB];
    assign bus.a_rvalid = rvalid[PA];
    assign bus.b_rvalid = rvalid[PB];

    a_one_ack: assert property (@(posedge clk) !(bus.a_ack && bus.b_ack));
    a_one_dir: assert property (@(posedge clk) !(bus.mem_mrd && bus.mem_mwr));
    a_one_rv:  assert property (@(posedge clk) !(bus.a_rvalid && bus.b_rvalid));
    a_no_back: assert property (@(posedge clk) disable iff (rst)
                                (state != IDLE) |=> (state_nxt != state || state == IDLE));
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter: a grant-history reference model plus
// directed sequences for the write/read, alternation, lone-requester and reset cases.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int G_NONE = 0;
    localparam int G_A    = 1;
    localparam int G_B    = 2;

    typedef struct packed {
        logic          req;
        logic          wr;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdata;
    } rq_t;

    localparam rq_t NOQ = '0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Memory seen by the DUT, and the reference copy kept by the model.
    logic [DW-1:0] mem  [0:1023];
    logic [DW-1:0] mmem [0:1023];

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hA500_0000 ^ 32'(i * 66051);
    endfunction

    assign bus.mem_d_out = mem[bus.mem_adr[11:2]];
    always @(posedge clk) if (bus.mem_mwr) mem[bus.mem_adr[11:2]] <= bus.mem_d_in;
    initial for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model state: who is granted this cycle, who was served last, pending read returns.
    int            g;
    int            last_g;
    logic          rv_a, rv_b;
    logic [DW-1:0] rd_a, rd_b;
    logic [3:0]    hist[$];   // {b_rvalid, a_rvalid, b_ack, a_ack} per step

    function automatic rq_t rdq(input logic [AW-1:0] a);
        return '{req: 1'b1, wr: 1'b0, adr: a, wdata: '0};
    endfunction

    function automatic rq_t wrq(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return '{req: 1'b1, wr: 1'b1, adr: a, wdata: d};
    endfunction

    // Nobody is served twice running; otherwise contention goes to whoever waited.
    function automatic int next_grant(input int cur, input logic ar, input logic br);
`ifdef ARB_FIXED_PRIO_EN
        if (ar && br) return (cur == G_A) ? G_NONE : G_A;
`else
        if (ar && br) begin
            if (cur == G_NONE) return (last_g == G_A) ? G_B : G_A;
            return (cur == G_A) ? G_B : G_A;
        end
`endif
        if (ar) return (cur == G_A) ? G_NONE : G_A;
        if (br) return (cur == G_B) ? G_NONE : G_B;
        return G_NONE;
    endfunction

    task automatic step(input rq_t a, input rq_t b, input logic r);
        logic          wr_g;
        logic [AW-1:0] adr_g;
        logic [DW-1:0] din_g;
        int            gn;
        @(posedge clk);
        #1;
        bus.a_req = a.req; bus.a_wr = a.wr; bus.a_adr = a.adr; bus.a_wdata = a.wdata;
        bus.b_req = b.req; bus.b_wr = b.wr; bus.b_adr = b.adr; bus.b_wdata = b.wdata;
        rst = r;
        @(negedge clk);
        wr_g  = (g == G_A) ? a.wr    : (g == G_B) ? b.wr    : 1'b0;
        adr_g = (g == G_A) ? a.adr   : (g == G_B) ? b.adr   : '0;
        din_g = (g == G_A) ? a.wdata : (g == G_B) ? b.wdata : '0;
        chk("a_ack",    64'(bus.a_ack),    64'((g == G_A) && !r));
        chk("b_ack",    64'(bus.b_ack),    64'((g == G_B) && !r));
        chk("mem_mwr",  64'(bus.mem_mwr),  64'((g != G_NONE) && wr_g && !r));
        chk("mem_mrd",  64'(bus.mem_mrd),  64'((g != G_NONE) && !wr_g && !r));
        chk("mem_adr",  64'(bus.mem_adr),  64'(adr_g));
        chk("mem_d_in", 64'(bus.mem_d_in), 64'(din_g));
        chk("a_rvalid", 64'(bus.a_rvalid), 64'(rv_a));
        chk("b_rvalid", 64'(bus.b_rvalid), 64'(rv_b));
        chk("a_rdata",  64'(bus.a_rdata),  64'(rd_a));
        chk("b_rdata",  64'(bus.b_rdata),  64'(rd_b));
        hist.push_back({bus.b_rvalid, bus.a_rvalid, bus.b_ack, bus.a_ack});
        rv_a = 1'b0;
        rv_b = 1'b0;
        if (r) begin
            gn     = G_NONE;
            last_g = G_B;
            rd_a   = '0;
            rd_b   = '0;
        end else begin
            if (g != G_NONE) begin
                if (wr_g) mmem[adr_g[11:2]] = din_g;
                else if (g == G_A) begin rd_a = mmem[adr_g[11:2]]; rv_a = 1'b1; end
                else begin rd_b = mmem[adr_g[11:2]]; rv_b = 1'b1; end
                last_g = g;
            end
            gn = next_grant(g, a.req, b.req);
        end
        g = gn;
    endtask

    logic [3:0] e34 [5];
    logic [3:0] e35 [6];

    initial begin
        rst = 1'b1;
        bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_adr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_adr = '0; bus.b_wdata = '0;
        for (int i = 0; i < 1024; i++) mmem[i] = init_val(i);
        g = G_NONE; last_g = G_B; rv_a = 1'b0; rv_b = 1'b0; rd_a = '0; rd_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ack",    64'(bus.a_ack),    64'(0));
        chk("rst_b_ack",    64'(bus.b_ack),    64'(0));
        chk("rst_mwr",      64'(bus.mem_mwr),  64'(0));
        chk("rst_mrd",      64'(bus.mem_mrd),  64'(0));
        chk("rst_a_rvalid", 64'(bus.a_rvalid), 64'(0));
        chk("rst_b_rvalid", 64'(bus.b_rvalid), 64'(0));
        chk("rst_a_rdata",  64'(bus.a_rdata),  64'(0));
        chk("rst_b_rdata",  64'(bus.b_rdata),  64'(0));

        // A writes 1000, B reads it back.
        step(wrq(1000, 32'hDEADBEEF), NOQ, 1'b0);
        step(wrq(1000, 32'hDEADBEEF), NOQ, 1'b0);
        step(NOQ, NOQ, 1'b0);
        step(NOQ, rdq(1000), 1'b0);
        step(NOQ, rdq(1000), 1'b0);
        step(NOQ, NOQ, 1'b0);
        chk("r033_b_rdata", 64'(bus.b_rdata), 64'(32'hDEADBEEF));

        // Both requesting from a fresh reset.
        step(NOQ, NOQ, 1'b1);
        hist.delete();
        repeat (5) step(rdq(1000), rdq(2000), 1'b0);
`ifdef ARB_FIXED_PRIO_EN
        e34 = '{4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
`else
        e34 = '{4'b0000, 4'b0001, 4'b0110, 4'b1001, 4'b0110};
`endif
        for (int i = 0; i < 5; i++) chk($sformatf("r034_seq%0d", i), 64'(hist[i]), 64'(e34[i]));

        // Lone A read held four cycles.
        step(NOQ, NOQ, 1'b1);
        hist.delete();
        repeat (4) step(rdq(1000), NOQ, 1'b0);
        repeat (2) step(NOQ, NOQ, 1'b0);
        e35 = '{4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0000};
        for (int i = 0; i < 6; i++) chk($sformatf("r035_seq%0d", i), 64'(hist[i]), 64'(e35[i]));

        // Reset lands on the SERVE_A cycle of a write to 2000.
        step(NOQ, NOQ, 1'b1);
        step(wrq(2000, 32'h1234_5678), NOQ, 1'b0);
        step(wrq(2000, 32'h1234_5678), NOQ, 1'b1);
        step(NOQ, NOQ, 1'b0);
        chk("r036_mem", 64'(mem[500]), 64'(init_val(500)));

        // B reads 2000 while A writes 2004 right after.
        step(NOQ, rdq(2000), 1'b0);
        step(wrq(2004, 32'hCAFE_F00D), rdq(2000), 1'b0);
        step(wrq(2004, 32'hCAFE_F00D), NOQ, 1'b0);
        step(NOQ, NOQ, 1'b0);
        chk("r037_b_rdata", 64'(bus.b_rdata), 64'(init_val(500)));
        chk("r037_a_rvalid", 64'(bus.a_rvalid), 64'(0));
        chk("r037_mem2004", 64'(mem[501]), 64'(32'hCAFE_F00D));

        // Random traffic over a small address window, occasional reset.
        for (int n = 0; n < 600; n++) begin
            rq_t ra, rb;
            ra.req   = ($urandom_range(0, 9) < 7);
            ra.wr    = 1'($urandom_range(0, 1));
            ra.adr   = 32'(2000 + 4 * $urandom_range(0, 7));
            ra.wdata = $urandom;
            rb.req   = ($urandom_range(0, 9) < 7);
            rb.wr    = 1'($urandom_range(0, 1));
            rb.adr   = 32'(2000 + 4 * $urandom_range(0, 7));
            rb.wdata = $urandom;
            step(ra, rb, ($urandom_range(0, 49) == 0));
        end
        repeat (2) step(NOQ, NOQ, 1'b0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("final_mem%0d", i), 64'(mem[500 + i]), 64'(mmem[500 + i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, sets the write-data and read-data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_req  input  1  requester A access request; held until a_ack.
REQ-006 a_wr  input  1  A direction: 1=write, 0=read.
REQ-007 a_adr  input  ADDR_W  A byte address.
REQ-008 a_wdata  input  DATA_W  A write data.
REQ-009 a_ack  output  1  A access driven to memory this cycle.
REQ-010 a_rdata  output  DATA_W  A registered read data.
REQ-011 a_rvalid  output  1  a_rdata valid, one-cycle pulse.
REQ-012 b_req, b_wr, b_adr, b_wdata, b_ack, b_rdata, b_rvalid  same as A, for requester B.
REQ-013 mem_adr  output  ADDR_W  memory address.
REQ-014 mem_d_in  output  DATA_W  memory write data.
REQ-015 mem_mrd  output  1  memory read enable.
REQ-016 mem_mwr  output  1  memory write enable; memory commits on posedge clk.
REQ-017 mem_d_out  input  DATA_W  memory combinational read data.

Function
REQ-018 FSM states IDLE, SERVE_A, SERVE_B; plus a 1-bit round-robin pointer, last (0=A last served, 1=B).
REQ-019 IDLE: only a_req -> SERVE_A; only b_req -> SERVE_B; both -> the requester not equal to last; none -> IDLE.
REQ-020 SERVE_A: the opposing req (b_req) is 1 -> SERVE_B; otherwise -> IDLE; last<=0. SERVE_B is symmetric, with last<=1.
REQ-021 Exactly one access per SERVE cycle; a lone requester therefore gets at most one access every 2 cycles.
REQ-022 In SERVE_X: mem_adr/mem_d_in = X inputs; mem_mwr = X_wr; mem_mrd = !X_wr; X_ack = 1.
REQ-023 In IDLE: mem_adr=0, mem_d_in=0, mem_mrd=0, mem_mwr=0, both acks 0.
REQ-024 Read in SERVE_X: mem_d_out is registered into X_rdata at the end of the cycle, and X_rvalid=1 for the following cycle only.
REQ-025 Latency: req rises in cycle n while IDLE -> ack in n+1 -> rvalid in n+2; write is committed at the end of n+1.
REQ-026 X_rdata holds its last value when X_rvalid=0; the non-served port's rdata is unchanged.
REQ-027 A req deasserted before ack means the request is abandoned without error; in SERVE_X the memory uses X inputs regardless.
REQ-028 a_ack and b_ack are never both 1; mem_mrd and mem_mwr are never both 1.

Reset
REQ-029 rst=1 at posedge: state=IDLE, last=1 (A favoured first), a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
REQ-030 While rst=1, mem_mwr, mem_mrd, a_ack and b_ack are forced 0 combinationally, so a SERVE-cycle write is suppressed by reset mid-operation.

Configuration
REQ-031 ARB_FIXED_PRIO_EN defined: A always wins when both request in IDLE or SERVE_B (B may starve), and last is ignored.
REQ-032 ARB_FIXED_PRIO_EN undefined: round-robin per REQ-019/020; neither requester waits more than one access of the other.

Verification
REQ-033 After reset, a_req=1, a_wr=1, a_adr=1000, a_wdata=0xDEADBEEF -> a_ack in the next cycle, with mem_mwr=1 and mem_adr=1000; later B read of 1000 -> b_rvalid with b_rdata=0xDEADBEEF.
REQ-034 Both req held from IDLE after reset -> grant sequence A,B,A,B, with acks in alternating consecutive cycles; with ARB_FIXED_PRIO_EN -> A,A,A.
REQ-035 A lone a_req read held for 4 cycles -> a_ack in cycles 1 and 3 with IDLE between, and a_rvalid in cycles 2 and 4.
REQ-036 rst=1 during a SERVE_A write to 2000 -> mem_mwr=0, and the location keeps its old value; the state is IDLE next cycle.
REQ-037 B read of 2000 while A writes 2004 next -> b_rdata equals the old mem[2000] value and is unaffected by A's write, and a_rvalid stays 0.
